cordic_sched: RTL and testbench
===============================

// Module: cordic_sched
// PURPOSE
//  Shares one two-phase CORDIC (cordic_mux) among 2**CW requesters. Arbitrates round-robin,
//  serialises each granted operand pair onto CORDIC phase 0/1, and tags the slot through a
//  delay line so each result returns to its requester. Sits between LLRF channel logic and cordic_mux.
// PARAMETERS
//  CW   2   channel index width; NCH = 2**CW requesters
//  DW   18  operand/result width (signed)
//  PW   19  phase operand width (signed)
//  LAT  20  cycles from phase-0 operand presented to phase-0 result valid on c_out_*; even, >=4
// PORTS
//  clk        in   1        system clock
//  rst        in   1        reset, asynchronous, active-high
//  req_valid  in   NCH      per-channel request pending
//  req_mode   in   NCH      0 = rect->polar (x,y), 1 = polar->rect (mag,ph)
//  req_a      in   NCH*DW   operand A (x or mag), channel k at [k*DW +: DW]
//  req_b      in   NCH*DW   operand B (y; ignored in mode 1)
//  req_ph     in   NCH*PW   phase operand (mode 1 only)
//  req_ready  out  NCH      one-hot grant pulse; request consumed on valid&ready
//  c_phase    out  1        to cordic_mux .phase
//  c_in_iq    out  DW       to cordic_mux .in_iq
//  c_in_xy    out  DW       to cordic_mux .in_xy
//  c_in_ph    out  PW       to cordic_mux .in_ph
//  c_out_iq   in   DW       from cordic_mux .out_iq (mode-1 results)
//  c_out_mp   in   DW       from cordic_mux .out_mp (mode-0 results)
//  res_valid  out  1        one-cycle pulse, result pair on res_*
//  res_ch     out  CW       channel the result belongs to
//  res_mode   out  1        mode of the result
//  res_a      out  DW       first result word (mag, or I)
//  res_b      out  DW       second result word (phase, or Q)
// BEHAVIOUR
//  - Reset: c_phase=0, req_ready=0, all c_in_*=0, res_*=0, RR pointer=0, tag line cleared.
//  - c_phase toggles every cycle; slot = phase-0 cycle plus following phase-1 cycle.
//  - Arbitration only in phase-0 cycles: first req_valid at or after RR pointer wins;
//    req_ready[k] high that cycle only; RR pointer <= k+1 (mod NCH). No grant in phase 1.
//  - Requester may drop req_valid any time before grant; no grant if none valid (idle slot).
//  - Granted operands registered; presented one cycle after grant:
//    mode 0: c_in_iq=A (phase 0), B (phase 1); c_in_xy=c_in_ph=0.
//    mode 1: c_in_xy=A, c_in_ph=ph (phase 0), c_in_xy=0 (phase 1); c_in_iq=0.
//    Idle slot: all c_in_* = 0. Unused inputs are never X.
//  - Tag line: LAT-deep shift of {valid,ch,mode}, advanced every cycle, written at phase 0.
//    At tag exit capture phase-0 word; next cycle capture phase-1 word and pulse res_valid
//    with tag fields. Source: c_out_mp (mode 0) or c_out_iq (mode 1).
//  - Grant-to-res_valid latency: LAT+2 cycles, fixed. Throughput 1 request / 2 cycles.
//  - No result back-pressure; consumers must accept every res_valid.
//  - Single requester held valid: granted every slot. All valid: strict rotation 0,1,..,NCH-1.
//  - Reset mid-operation: in-flight tags discarded, no res_valid for them; grants restart at ch 0.
// STRUCTURE
//  - Package cordic_sched_pkg: mode encodings MODE_R2P=0/MODE_P2R=1, tag struct {valid,ch,mode}.
//  - Sub-module rr_arb (NCH-way round-robin, enable input, one-hot grant + index out).
//  - Top: phase toggle, operand regs, tag shift line, result capture.
// TESTING (bench instantiates cordic_sched + cordic_mux, LAT matched)
//  1 rst 3 cycles, no requests -> req_ready=0, res_valid never, c_in_* all 0.
//  2 ch1 mode0 A=1000,B=0 -> one grant on phase 0, res_valid at grant+LAT+2, res_ch=1,
//    res_a~1000*CORDIC gain, res_b~0 (tolerance +/-4 LSB).
//  3 ch2 mode1 A=3000 ph=0 -> res_ch=2, res_mode=1, res_a~3000*gain, res_b~0.
//  4 all 4 ch valid continuously, 16 slots -> grants rotate 0,1,2,3 x4; 16 res_valid in order, tags match.
//  5 ch0 valid only in a phase-1 cycle, dropped next cycle -> no grant, no result.
//  6 assert rst with 3 requests in flight -> outputs to reset values at once, no stale
//    res_valid after release; next grant to ch 0.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
// Shared definitions for the CORDIC request scheduler.
//   MODE_R2P / MODE_P2R : request mode encodings (rect->polar, polar->rect)
//   TAG_CH_W            : channel field width carried in a result tag (>= CW)
//   tag_t               : {valid, ch, mode} travelling alongside a CORDIC slot
package cordic_sched_pkg;

    localparam logic MODE_R2P = 1'b0;
    localparam logic MODE_P2R = 1'b1;

    // Channel field is sized for the largest supported CW; the top casts in and out.
    localparam int TAG_CH_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_CH_W-1:0] ch;
        logic                mode;
    } tag_t;

endpackage

// File: rtl/cordic_sched_rr_arb.sv
// N-way round-robin arbiter (N = 2**IW).
//   clk, rst : clock, asynchronous active-high reset (pointer to 0)
//   en       : arbitrate this cycle; no grant and no pointer move when low
//   req      : request vector
//   gnt      : one-hot grant (combinational)
//   idx      : index of the winning request
//   hit      : a grant is issued this cycle
// The first request at or after the pointer wins; the pointer then moves to winner+1.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          hit
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // IW-bit addition wraps naturally because N == 2**IW.
        for (int i = 0; i < N; i++) begin
            cand = ptr + IW'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        hit = en & found;
        gnt = '0;
        if (hit) gnt[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= idx + IW'(1);
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one two-phase CORDIC among 2**CW requesters.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-channel request handshake
//   req_mode/a/b/ph     : per-channel operands, channel k at [k*W +: W]
//   c_phase, c_in_*     : operand stream to the CORDIC
//   c_out_iq, c_out_mp  : CORDIC result words (mode 1 / mode 0)
//   res_*               : result pulse with channel and mode tag
//
// Handshake: a request is consumed in the cycle where req_valid[k] & req_ready[k];
// req_ready is a one-hot combinational grant raised only in arbitration cycles, so a
// requester may change or drop req_valid freely until it sees ready.
//
// Timing: sph is the slot phase. Grants happen when sph==0; the granted operands are
// registered and shown on the next cycle together with c_phase=0, so c_phase is always
// ~sph. LAT counts clock edges from the edge launching the phase-0 operand to the edge
// that samples the phase-0 result, which places res_valid LAT+2 cycles after the grant.
// LAT must be even and at least 4.
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int CW  = 2,
    parameter int DW  = 18,
    parameter int PW  = 19,
    parameter int LAT = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(2**CW)-1:0]    req_valid,
    input  logic [(2**CW)-1:0]    req_mode,
    input  logic [(2**CW)*DW-1:0] req_a,
    input  logic [(2**CW)*DW-1:0] req_b,
    input  logic [(2**CW)*PW-1:0] req_ph,
    output logic [(2**CW)-1:0]    req_ready,
    output logic                  c_phase,
    output logic [DW-1:0]         c_in_iq,
    output logic [DW-1:0]         c_in_xy,
    output logic [PW-1:0]         c_in_ph,
    input  logic [DW-1:0]         c_out_iq,
    input  logic [DW-1:0]         c_out_mp,
    output logic                  res_valid,
    output logic [CW-1:0]         res_ch,
    output logic                  res_mode,
    output logic [DW-1:0]         res_a,
    output logic [DW-1:0]         res_b
);

    localparam int NCH = 2**CW;

    logic          sph;
    logic [CW-1:0] gnt_idx;
    logic          gnt_hit;
    logic          gnt_mode;
    logic [DW-1:0] gnt_a;
    logic [DW-1:0] gnt_b;
    logic [PW-1:0] gnt_ph;

    // Second-phase state of the slot currently on the CORDIC inputs.
    logic          hold_v;
    logic          hold_mode;
    logic [DW-1:0] hold_b;

    tag_t          new_tag;
    tag_t          tag_q [LAT];
    tag_t          exit_tag;
    tag_t          pend;
    logic [DW-1:0] word0;

    rr_arb #(
        .N  (NCH),
        .IW (CW)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (~sph),
        .req (req_valid),
        .gnt (req_ready),
        .idx (gnt_idx),
        .hit (gnt_hit)
    );

    assign gnt_mode = req_mode[gnt_idx];
    assign gnt_a    = req_a[gnt_idx*DW +: DW];
    assign gnt_b    = req_b[gnt_idx*DW +: DW];
    assign gnt_ph   = req_ph[gnt_idx*PW +: PW];

    // Phase toggle and operand serialisation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sph       <= 1'b1;
            c_phase   <= 1'b0;
            c_in_iq   <= '0;
            c_in_xy   <= '0;
            c_in_ph   <= '0;
            hold_v    <= 1'b0;
            hold_mode <= MODE_R2P;
            hold_b    <= '0;
        end else begin
            sph     <= ~sph;
            c_phase <= sph;
            if (!sph) begin
                hold_v    <= gnt_hit;
                hold_mode <= gnt_mode;
                hold_b    <= gnt_b;
                c_in_iq   <= '0;
                c_in_xy   <= '0;
                c_in_ph   <= '0;
                if (gnt_hit) begin
                    if (gnt_mode == MODE_R2P) begin
                        c_in_iq <= gnt_a;
                    end else begin
                        c_in_xy <= gnt_a;
                        c_in_ph <= gnt_ph;
                    end
                end
            end else begin
                c_in_xy <= '0;
                c_in_ph <= '0;
                c_in_iq <= (hold_v && hold_mode == MODE_R2P) ? hold_b : '0;
            end
        end
    end

    // A tag enters only on a grant, which only happens when sph==0, so odd stages stay empty.
    always_comb begin
        new_tag       = '0;
        new_tag.valid = gnt_hit;
        new_tag.ch    = TAG_CH_W'(gnt_idx);
        new_tag.mode  = gnt_mode;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= new_tag;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign exit_tag = tag_q[LAT-1];

    // exit_tag lines up with the phase-0 result word; pend with the phase-1 word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            word0     <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_mode  <= MODE_R2P;
            res_a     <= '0;
            res_b     <= '0;
        end else begin
            pend      <= exit_tag;
            res_valid <= pend.valid;
            if (exit_tag.valid) begin
                word0 <= (exit_tag.mode == MODE_P2R) ? c_out_iq : c_out_mp;
            end
            if (pend.valid) begin
                res_ch   <= CW'(pend.ch);
                res_mode <= pend.mode;
                res_a    <= word0;
                res_b    <= (pend.mode == MODE_P2R) ? c_out_iq : c_out_mp;
            end
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched. The CORDIC is a stand-in model: each output word is the
// matching input word scaled by the CORDIC gain (~1.6468) and delayed so that the
// phase-0 result is sampled LAT edges after the phase-0 operand is launched.
module tb_cordic_sched;

  localparam int CW  = 2;
  localparam int NCH = 4;
  localparam int DW  = 18;
  localparam int PW  = 19;
  localparam int LAT = 20;

  logic                clk;
  logic                rst;
  logic [NCH-1:0]      req_valid;
  logic [NCH-1:0]      req_mode;
  logic [NCH*DW-1:0]   req_a;
  logic [NCH*DW-1:0]   req_b;
  logic [NCH*PW-1:0]   req_ph;
  logic [NCH-1:0]      req_ready;
  logic                c_phase;
  logic [DW-1:0]       c_in_iq;
  logic [DW-1:0]       c_in_xy;
  logic [PW-1:0]       c_in_ph;
  logic [DW-1:0]       c_out_iq;
  logic [DW-1:0]       c_out_mp;
  logic                res_valid;
  logic [CW-1:0]       res_ch;
  logic                res_mode;
  logic [DW-1:0]       res_a;
  logic [DW-1:0]       res_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cordic_sched #(.CW(CW), .DW(DW), .PW(PW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ph    (req_ph),
    .req_ready (req_ready),
    .c_phase   (c_phase),
    .c_in_iq   (c_in_iq),
    .c_in_xy   (c_in_xy),
    .c_in_ph   (c_in_ph),
    .c_out_iq  (c_out_iq),
    .c_out_mp  (c_out_mp),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_mode  (res_mode),
    .res_a     (res_a),
    .res_b     (res_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- CORDIC stand-in ----------------
  function automatic int gain(input int x);
    return x * 1647 / 1000;
  endfunction

  logic [DW-1:0] mp_pipe [LAT-1];
  logic [DW-1:0] iq_pipe [LAT-1];

  initial begin
    for (int i = 0; i < LAT-1; i++) begin
      mp_pipe[i] = '0;
      iq_pipe[i] = '0;
    end
  end

  always @(posedge clk) begin
    mp_pipe[0] <= DW'(gain(int'($signed(c_in_iq))));
    iq_pipe[0] <= DW'(gain(int'($signed(c_in_xy))));
    for (int i = 1; i < LAT-1; i++) begin
      mp_pipe[i] <= mp_pipe[i-1];
      iq_pipe[i] <= iq_pipe[i-1];
    end
  end

  assign c_out_mp = mp_pipe[LAT-2];
  assign c_out_iq = iq_pipe[LAT-2];

  // ---------------- monitors ----------------
  int            gnt_cyc_q[$];
  int            gnt_ch_q[$];
  int            res_cyc_q[$];
  int            res_ch_q[$];
  logic          res_mode_q[$];
  logic [DW-1:0] res_a_q[$];
  logic [DW-1:0] res_b_q[$];
  logic [CW+DW-1:0] exp_q[$];

  always @(negedge clk) begin
    #2;
    if (req_ready !== '0) begin
      gnt_cyc_q.push_back(cyc);
      gnt_ch_q.push_back($clog2(int'(req_ready)));
    end
  end

  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      res_cyc_q.push_back(cyc);
      res_ch_q.push_back(int'(res_ch));
      res_mode_q.push_back(res_mode);
      res_a_q.push_back(res_a);
      res_b_q.push_back(res_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic flush();
    gnt_cyc_q.delete();
    gnt_ch_q.delete();
    res_cyc_q.delete();
    res_ch_q.delete();
    res_mode_q.delete();
    res_a_q.delete();
    res_b_q.delete();
    exp_q.delete();
  endtask

  task automatic set_ops(input int ch, input logic mode, input int a, input int b, input int ph);
    req_mode[ch]           = mode;
    req_a[ch*DW +: DW]     = DW'(a);
    req_b[ch*DW +: DW]     = DW'(b);
    req_ph[ch*PW +: PW]    = PW'(ph);
  endtask

  // Holds one request valid until granted; returns at the negedge after the grant.
  task automatic send(input int ch, input logic mode, input int a, input int b, input int ph,
                      output int gcyc, output bit ok);
    @(negedge clk);
    set_ops(ch, mode, a, b, ph);
    req_valid[ch] = 1'b1;
    ok = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 8 && !ok; i++) begin
      #2;
      if (req_ready[ch] === 1'b1) begin
        ok = 1'b1;
        gcyc = cyc;
      end
      @(negedge clk);
    end
    req_valid[ch] = 1'b0;
  endtask

  task automatic wait_res(input int n, input int bound, output bit ok);
    for (int i = 0; i < bound && res_cyc_q.size() < n; i++) begin
      @(negedge clk);
      #3;
    end
    ok = (res_cyc_q.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic prev;
    rst = 1'b1;
    req_valid = '0;
    req_mode = '0;
    req_a = '0;
    req_b = '0;
    req_ph = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({c_phase, req_ready, res_valid, c_in_iq, c_in_xy, c_in_ph, res_ch, res_mode, res_a, res_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: c_phase=%0b ready=%0b res_valid=%0b iq=%0d xy=%0d ph=%0d res_a=%0d res_b=%0d, required all 0",
               c_phase, req_ready, res_valid, c_in_iq, c_in_xy, c_in_ph, res_a, res_b);
    end
    rst = 1'b0;
    prev = c_phase;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({req_ready, res_valid, c_in_iq, c_in_xy, c_in_ph} !== '0) begin
        errors++;
        $display("FAIL idle_outputs: ready=%0b res_valid=%0b iq=%0d xy=%0d ph=%0d, required all 0",
                 req_ready, res_valid, c_in_iq, c_in_xy, c_in_ph);
      end
      checks++;
      if (c_phase !== ~prev) begin
        errors++;
        $display("FAIL phase_toggle: c_phase=%0b required %0b", c_phase, ~prev);
      end
      prev = c_phase;
    end
  endtask

  task automatic test_rotation();
    int a_cur[NCH];
    int n;
    int pend_ch;
    logic [CW+DW-1:0] e;
    bit ok;
    flush();
    for (int k = 0; k < NCH; k++) begin
      a_cur[k] = 100 * (k + 1);
      set_ops(k, 1'b0, a_cur[k], 0, 0);
    end
    n = 0;
    pend_ch = -1;
    @(negedge clk);
    req_valid = '1;
    for (int i = 0; i < 60 && n < 16; i++) begin
      if (pend_ch >= 0) begin
        a_cur[pend_ch] = 100 * (pend_ch + 1) + 7 * n;
        set_ops(pend_ch, 1'b0, a_cur[pend_ch], 0, 0);
        pend_ch = -1;
      end
      #2;
      if (req_ready !== '0) begin
        checks++;
        if (req_ready !== NCH'(1 << (n % NCH))) begin
          errors++;
          $display("FAIL rot_grant: grant %0d ready=%b required %b", n, req_ready, NCH'(1 << (n % NCH)));
        end
        exp_q.push_back({CW'(n % NCH), DW'(a_cur[n % NCH])});
        pend_ch = n % NCH;
        n++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL rot_grant_count: got %0d required 16", n);
    end
    wait_res(16, LAT + 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rot_result_count: got %0d required 16", res_cyc_q.size());
    end
    for (int i = 0; i < res_cyc_q.size() && i < 16; i++) begin
      e = exp_q[i];
      checks++;
      if (res_ch_q[i] != int'(e[CW+DW-1:DW]) || res_mode_q[i] !== 1'b0) begin
        errors++;
        $display("FAIL rot_tag: result %0d ch=%0d mode=%0b required ch=%0d mode=0",
                 i, res_ch_q[i], res_mode_q[i], e[CW+DW-1:DW]);
      end
      checks++;
      if (int'($signed(res_a_q[i])) < gain(int'(e[DW-1:0])) - 4 ||
          int'($signed(res_a_q[i])) > gain(int'(e[DW-1:0])) + 4 ||
          int'($signed(res_b_q[i])) < -4 || int'($signed(res_b_q[i])) > 4) begin
        errors++;
        $display("FAIL rot_data: result %0d res_a=%0d res_b=%0d required ~%0d and ~0",
                 i, $signed(res_a_q[i]), $signed(res_b_q[i]), gain(int'(e[DW-1:0])));
      end
      if (i > 0) begin
        checks++;
        if (res_cyc_q[i] - res_cyc_q[i-1] != 2) begin
          errors++;
          $display("FAIL rot_spacing: result %0d gap=%0d required 2", i, res_cyc_q[i] - res_cyc_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_r2p();
    int g;
    bit ok;
    int ra;
    int rb;
    flush();
    send(1, 1'b0, 1000, 0, 0, g, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL r2p_grant: no grant seen for ch1");
    end
    #1;
    checks++;
    if (c_phase !== 1'b0 || c_in_iq !== 18'd1000 || c_in_xy !== '0 || c_in_ph !== '0) begin
      errors++;
      $display("FAIL r2p_op0: c_phase=%0b iq=%0d xy=%0d ph=%0d required 0/1000/0/0",
               c_phase, c_in_iq, c_in_xy, c_in_ph);
    end
    @(negedge clk);
    #1;
    checks++;
    if (c_phase !== 1'b1 || c_in_iq !== '0) begin
      errors++;
      $display("FAIL r2p_op1: c_phase=%0b iq=%0d required 1/0", c_phase, c_in_iq);
    end
    wait_res(1, LAT + 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL r2p_result: no res_valid seen");
    end else begin
      checks++;
      if (res_cyc_q[0] - g != LAT + 2) begin
        errors++;
        $display("FAIL r2p_latency: got %0d required %0d", res_cyc_q[0] - g, LAT + 2);
      end
      checks++;
      if (res_ch_q[0] != 1 || res_mode_q[0] !== 1'b0) begin
        errors++;
        $display("FAIL r2p_tag: ch=%0d mode=%0b required 1/0", res_ch_q[0], res_mode_q[0]);
      end
      ra = int'($signed(res_a_q[0]));
      rb = int'($signed(res_b_q[0]));
      checks++;
      if (ra < 1647 - 4 || ra > 1647 + 4 || rb < -4 || rb > 4) begin
        errors++;
        $display("FAIL r2p_data: res_a=%0d res_b=%0d required ~1647 and ~0", ra, rb);
      end
    end
    repeat (6) @(negedge clk);
    #3;
    checks++;
    if (res_cyc_q.size() != 1 || gnt_ch_q.size() != 1) begin
      errors++;
      $display("FAIL r2p_single: results=%0d grants=%0d required 1/1", res_cyc_q.size(), gnt_ch_q.size());
    end
  endtask

  task automatic test_p2r();
    int g;
    bit ok;
    int ra;
    int rb;
    flush();
    send(2, 1'b1, 3000, 0, 0, g, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL p2r_grant: no grant seen for ch2");
    end
    #1;
    checks++;
    if (c_phase !== 1'b0 || c_in_xy !== 18'd3000 || c_in_iq !== '0 || c_in_ph !== '0) begin
      errors++;
      $display("FAIL p2r_op0: c_phase=%0b xy=%0d iq=%0d ph=%0d required 0/3000/0/0",
               c_phase, c_in_xy, c_in_iq, c_in_ph);
    end
    wait_res(1, LAT + 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL p2r_result: no res_valid seen");
    end else begin
      checks++;
      if (res_cyc_q[0] - g != LAT + 2 || res_ch_q[0] != 2 || res_mode_q[0] !== 1'b1) begin
        errors++;
        $display("FAIL p2r_tag: latency=%0d ch=%0d mode=%0b required %0d/2/1",
                 res_cyc_q[0] - g, res_ch_q[0], res_mode_q[0], LAT + 2);
      end
      ra = int'($signed(res_a_q[0]));
      rb = int'($signed(res_b_q[0]));
      checks++;
      if (ra < 4940 - 4 || ra > 4940 + 4 || rb < -4 || rb > 4) begin
        errors++;
        $display("FAIL p2r_data: res_a=%0d res_b=%0d required ~4940 and ~0", ra, rb);
      end
    end
  endtask

  task automatic test_operands();
    int g;
    bit ok;
    int ra;
    int rb;
    flush();
    send(3, 1'b0, 500, -200, 0, g, ok);
    #1;
    checks++;
    if (!ok || c_in_iq !== 18'd500 || c_phase !== 1'b0) begin
      errors++;
      $display("FAIL ops_r2p_a: ok=%0b iq=%0d c_phase=%0b required 1/500/0", ok, c_in_iq, c_phase);
    end
    @(negedge clk);
    #1;
    checks++;
    if ($signed(c_in_iq) !== -18'sd200 || c_in_xy !== '0 || c_in_ph !== '0) begin
      errors++;
      $display("FAIL ops_r2p_b: iq=%0d xy=%0d ph=%0d required -200/0/0", $signed(c_in_iq), c_in_xy, c_in_ph);
    end
    send(0, 1'b1, 700, 55, 1234, g, ok);
    #1;
    checks++;
    if (!ok || c_in_xy !== 18'd700 || c_in_ph !== 19'd1234 || c_in_iq !== '0) begin
      errors++;
      $display("FAIL ops_p2r_0: ok=%0b xy=%0d ph=%0d iq=%0d required 1/700/1234/0", ok, c_in_xy, c_in_ph, c_in_iq);
    end
    @(negedge clk);
    #1;
    checks++;
    if (c_in_xy !== '0 || c_in_iq !== '0) begin
      errors++;
      $display("FAIL ops_p2r_1: xy=%0d iq=%0d required 0/0", c_in_xy, c_in_iq);
    end
    wait_res(2, LAT + 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ops_results: got %0d required 2", res_cyc_q.size());
    end else begin
      ra = int'($signed(res_a_q[0]));
      rb = int'($signed(res_b_q[0]));
      checks++;
      if (res_ch_q[0] != 3 || ra < 823 - 4 || ra > 823 + 4 || rb < -329 - 4 || rb > -329 + 4) begin
        errors++;
        $display("FAIL ops_r2p_res: ch=%0d res_a=%0d res_b=%0d required 3/~823/~-329", res_ch_q[0], ra, rb);
      end
      checks++;
      if (res_ch_q[1] != 0 || res_mode_q[1] !== 1'b1) begin
        errors++;
        $display("FAIL ops_p2r_res: ch=%0d mode=%0b required 0/1", res_ch_q[1], res_mode_q[1]);
      end
    end
  endtask

  task automatic test_phase1_drop();
    flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (c_phase === 1'b0) break;
    end
    checks++;
    if (c_phase !== 1'b0) begin
      errors++;
      $display("FAIL drop_sync: c_phase=%0b required 0", c_phase);
    end
    set_ops(0, 1'b0, 900, 0, 0);
    req_valid[0] = 1'b1;
    #2;
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL drop_ready_p1: ready=%b required 0000", req_ready);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    #2;
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL drop_ready_p0: ready=%b required 0000", req_ready);
    end
    repeat (LAT + 8) @(negedge clk);
    #3;
    checks++;
    if (gnt_ch_q.size() != 0 || res_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL drop_none: grants=%0d results=%0d required 0/0", gnt_ch_q.size(), res_cyc_q.size());
    end
  endtask

  task automatic test_reset_midop();
    int n;
    flush();
    set_ops(1, 1'b0, 1111, 0, 0);
    set_ops(2, 1'b0, 2222, 0, 0);
    @(negedge clk);
    req_valid = 4'b0110;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      #2;
      if (req_ready !== '0) n++;
      @(negedge clk);
    end
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL midop_grants: got %0d required 3", n);
    end
    checks++;
    if ({c_phase, req_ready, res_valid, c_in_iq, c_in_xy, c_in_ph} !== '0) begin
      errors++;
      $display("FAIL midop_async: c_phase=%0b ready=%b res_valid=%0b iq=%0d xy=%0d ph=%0d required all 0",
               c_phase, req_ready, res_valid, c_in_iq, c_in_xy, c_in_ph);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 12) @(negedge clk);
    #3;
    checks++;
    if (res_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL midop_stale: got %0d results required 0", res_cyc_q.size());
    end
    gnt_ch_q.delete();
    gnt_cyc_q.delete();
    @(negedge clk);
    for (int k = 0; k < NCH; k++) set_ops(k, 1'b0, 10 * (k + 1), 0, 0);
    req_valid = '1;
    for (int i = 0; i < 6 && gnt_ch_q.size() == 0; i++) begin
      @(negedge clk);
      #3;
    end
    req_valid = '0;
    checks++;
    if (gnt_ch_q.size() == 0) begin
      errors++;
      $display("FAIL midop_regrant: no grant after reset");
    end else if (gnt_ch_q[0] != 0) begin
      errors++;
      $display("FAIL midop_regrant: first grant ch=%0d required 0", gnt_ch_q[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_mode = '0;
    req_a = '0;
    req_b = '0;
    req_ph = '0;
    test_reset();
    test_rotation();
    test_r2p();
    test_p2r();
    test_operands();
    test_phase1_drop();
    test_reset_midop();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
